// File: rtl/rv32_ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package rv32_ifetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int RV32_IQ_DEPTH = 4;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_ifetch_queue_if.sv
// Bus bundle for the fetch queue: instruction memory port, redirect input, decode handshake.
interface rv32_ifetch_queue_if;
  import rv32_ifetch_queue_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  // Decode handshake: a beat transfers on a rising clk edge where instr_valid && instr_ready.
  // While instr_valid is high and no transfer happens, instr and instr_pc hold their values.
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/rv32_ifetch_queue_fifo.sv
// Small synchronous FIFO with flush; push and pop may coincide, flush wins over both.
module rv32_ifetch_queue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rv32_ifetch_queue.sv
// Fetch front end: PC, single-outstanding issue with credit check, drop flag, decode-side queue.
module rv32_ifetch_queue
  import rv32_ifetch_queue_pkg::*;
#(
  parameter int              DEPTH    = RV32_IQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  rv32_ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] last_pc;
  logic            inflight;
  logic            drop;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            issue;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    entry_in;

  // Credits count outstanding reads as occupied, so every response is guaranteed a slot.
  assign used     = {1'b0, count} + (CW+1)'(inflight);
  assign issue    = rst_n && !bus.redirect_valid && (used < DEPTH_W);
  assign push     = bus.imem_rvalid && inflight && !drop && !bus.redirect_valid;
  assign pop      = bus.instr_valid && bus.instr_ready;
  assign entry_in = '{pc: req_pc, instr: bus.imem_rdata};

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = bus.instr_valid ? head.instr : RV32_NOP;
  assign bus.instr_pc    = bus.instr_valid ? head.pc : last_pc;

  rv32_ifetch_queue_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .din   (entry_in),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      last_pc  <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (bus.instr_valid) last_pc <= head.pc;
      if (issue) req_pc <= pc;

      if (bus.redirect_valid) begin
        pc   <= bus.redirect_pc & ~32'h3;
        drop <= inflight && !bus.imem_rvalid;
      end else begin
        if (issue) pc <= pc + 32'd4;
        if (bus.imem_rvalid && drop) drop <= 1'b0;
      end

      if (issue) inflight <= 1'b1;
      else if (bus.imem_rvalid) inflight <= 1'b0;
    end
  end

  // A response with nothing outstanding means the memory side broke the fixed-latency contract.
  rvalid_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_rvalid |-> inflight);

endmodule

// File: tb/tb_rv32_ifetch_queue.sv
// Bench for rv32_ifetch_queue: directed scenarios then random traffic against a queue-based model.
module tb_rv32_ifetch_queue;
  import rv32_ifetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_ifetch_queue_if bus ();

  rv32_ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: delivered-order expectations {pc, instr}, and outstanding reads {keep, pc}.
  logic [63:0] exp_q[$];
  logic [32:0] fly_q[$];
  logic [31:0] m_pc      = RESET_PC;
  logic [31:0] m_last_pc = 32'h0;
  logic [31:0] salt      = 32'h0;
  logic        pend_v    = 1'b0;
  logic [31:0] pend_a    = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic r_n, input logic redir, input logic [31:0] rpc, input logic rdy);
    logic        exp_req;
    logic        rsp;
    logic [32:0] ent;
    rst_n              = r_n;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
    bus.imem_rvalid    = pend_v;
    bus.imem_rdata     = pend_a ^ salt;
    rsp                = pend_v;
    #2;
    exp_req = r_n && !redir && ((exp_q.size() + fly_q.size()) < DEPTH);
    check_eq("imem_req", {31'h0, bus.imem_req}, {31'h0, exp_req});
    if (exp_req) check_eq("imem_addr", bus.imem_addr, m_pc);
    check_eq("instr_valid", {31'h0, bus.instr_valid}, {31'h0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("instr", bus.instr, exp_q[0][31:0]);
      check_eq("instr_pc", bus.instr_pc, exp_q[0][63:32]);
    end else begin
      check_eq("instr_empty", bus.instr, RV32_NOP);
      check_eq("instr_pc_empty", bus.instr_pc, m_last_pc);
    end

    pend_v = bus.imem_req;
    pend_a = bus.imem_addr;

    if (!r_n) begin
      exp_q.delete();
      fly_q.delete();
      m_pc      = RESET_PC;
      m_last_pc = 32'h0;
    end else begin
      if (exp_q.size() != 0) m_last_pc = exp_q[0][63:32];
      if (!redir && rdy && exp_q.size() != 0) void'(exp_q.pop_front());
      if (rsp && fly_q.size() != 0) begin
        ent = fly_q.pop_front();
        if (ent[32] && !redir) exp_q.push_back({ent[31:0], ent[31:0] ^ salt});
      end
      if (redir) begin
        exp_q.delete();
        foreach (fly_q[i]) fly_q[i][32] = 1'b0;
        m_pc = rpc & ~32'h3;
      end else if (exp_req) begin
        fly_q.push_back({1'b1, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values, then streaming with data == address
    step(1'b0, 1'b0, 32'h0, 1'b1);
    run(12, 1'b1);

    // Back-pressure from an empty queue: fills to DEPTH, then drains in order
    step(1'b0, 1'b0, 32'h0, 1'b0);
    run(10, 1'b0);
    run(10, 1'b1);

    // Redirect to an unaligned target with three queued and one in flight
    step(1'b0, 1'b0, 32'h0, 1'b0);
    run(4, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    run(8, 1'b1);

    // Redirect coinciding with a pop and a returning read
    run(6, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    run(8, 1'b1);

    // Address wrap at the top of the space
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run(8, 1'b1);

    // Reset with a loaded queue and a read outstanding
    step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
    run(4, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    run(8, 1'b1);

    // Random traffic
    salt = $urandom;
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
